// File: rtl/alu_pkg.sv
// Types and bit positions shared by the operand sequencer and the ALU's muxes.
// Pure declarations: no logic, no latency, no flow control.
package alu_pkg;

    typedef enum logic [1:0] {
        CARGA_A  = 2'b00,
        CARGA_B  = 2'b01,
        CARGA_OP = 2'b10,
        LISTO    = 2'b11
    } etapa_t;

    localparam int OP_BIT  = 3;
    localparam int SEL_MSB = 2;
    localparam int SEL_LSB = 0;

endpackage

// File: rtl/secuenciador_operandos_if.sv
// Switch bus, load/clear buttons and the operand/opcode set presented to the ALU.
// Plain wires; the ALU side is a level interface qualified by valido, with no backpressure.
interface secuenciador_operandos_if #(
    parameter int N = 8
);
    logic [N-1:0] din;
    logic         cargar;
    logic         borrar;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   selector1;
    logic [2:0]   selector2;
    logic         operacion;
    logic         valido;
    logic [1:0]   etapa;
    logic [7:0]   operaciones;

    modport master (
        output din, cargar, borrar,
        input  A, B, selector1, selector2, operacion, valido, etapa, operaciones
    );

    modport slave (
        input  din, cargar, borrar,
        output A, B, selector1, selector2, operacion, valido, etapa, operaciones
    );
endinterface

// File: rtl/detector_flanco.sv
// Rising-edge detector for a synchronized level input; pulse is combinational from the
// input and one register. The reset value keeps a level held through reset from firing.
module detector_flanco #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_dato,
    output logic o_pulso
);
    logic r_dato_q;

    always_ff @(posedge clk) begin
        if (!rst_n) r_dato_q <= RST_VAL;
        else        r_dato_q <= i_dato;
    end

    assign o_pulso = i_dato & ~r_dato_q;
endmodule

// File: rtl/secuenciador_operandos.sv
// Loads A, B and opcode from one switch bus on successive button presses and holds them with valido.
// Outputs registered, 1 clock after the sampled rising edge of cargar; no backpressure.
module secuenciador_operandos
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    secuenciador_operandos_if.slave bus
);
    logic         w_pulso;
    etapa_t       r_etapa;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [2:0]   r_sel;
    logic         r_operacion;
    logic         r_valido;
    logic [7:0]   r_operaciones;

    // Reset value 1: a button held through reset must be released before it can load.
    detector_flanco #(.RST_VAL(1'b1)) u_flanco (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_dato  (bus.cargar),
        .o_pulso (w_pulso)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_etapa       <= CARGA_A;
            r_a           <= '0;
            r_b           <= '0;
            r_sel         <= '0;
            r_operacion   <= 1'b0;
            r_valido      <= 1'b0;
            r_operaciones <= 8'd0;
        end else if (bus.borrar) begin
            // The setup count survives a clear; only reset zeroes it.
            r_etapa     <= CARGA_A;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_operacion <= 1'b0;
            r_valido    <= 1'b0;
        end else if (w_pulso) begin
            case (r_etapa)
                CARGA_A: begin
                    r_a     <= bus.din;
                    r_etapa <= CARGA_B;
                end
                CARGA_B: begin
                    r_b     <= bus.din;
                    r_etapa <= CARGA_OP;
                end
                CARGA_OP: begin
                    r_operacion   <= bus.din[OP_BIT];
                    r_sel         <= bus.din[SEL_MSB:SEL_LSB];
                    r_valido      <= 1'b1;
                    r_operaciones <= r_operaciones + 8'd1;
                    r_etapa       <= LISTO;
                end
                LISTO: begin
                    r_valido <= 1'b0;
                    r_etapa  <= CARGA_A;
                end
                default: r_etapa <= CARGA_A;
            endcase
        end
    end

    assign bus.A           = r_a;
    assign bus.B           = r_b;
    assign bus.selector1   = r_sel;
    assign bus.selector2   = r_sel;
    assign bus.operacion   = r_operacion;
    assign bus.valido      = r_valido;
    assign bus.etapa       = r_etapa;
    assign bus.operaciones = r_operaciones;
endmodule

// File: tb/tb_secuenciador_operandos.sv
// Bench for secuenciador_operandos: directed scenarios plus random traffic against a press-count model.
module tb_secuenciador_operandos;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    secuenciador_operandos_if #(.N(8)) bus ();

    secuenciador_operandos #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stage is simply the number of presses since reset/clear, modulo 4.
    logic [7:0] m_a, m_b, m_cnt;
    logic [2:0] m_sel;
    logic       m_op, m_val, m_prev;
    int         m_presses;

    task automatic model_step(input logic r, input logic [7:0] d, input logic c, input logic bo);
        logic edge_seen;
        if (!r) begin
            m_a = 0; m_b = 0; m_sel = 0; m_op = 0; m_val = 0; m_cnt = 0;
            m_presses = 0; m_prev = 1'b1;
        end else begin
            edge_seen = c && !m_prev;
            m_prev = c;
            if (bo) begin
                m_a = 0; m_b = 0; m_sel = 0; m_op = 0; m_val = 0; m_presses = 0;
            end else if (edge_seen) begin
                case (m_presses % 4)
                    0: m_a = d;
                    1: m_b = d;
                    2: begin
                        m_op = d[3]; m_sel = d[2:0]; m_val = 1; m_cnt = m_cnt + 1;
                    end
                    default: m_val = 0;
                endcase
                m_presses = (m_presses + 1) % 4;
            end
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, return at the next falling edge.
    task automatic cycle(input logic r, input logic [7:0] d, input logic c, input logic bo);
        rst_n = r; bus.din = d; bus.cargar = c; bus.borrar = bo;
        @(posedge clk);
        model_step(r, d, c, bo);
        @(negedge clk);
    endtask

    task automatic press(input logic [7:0] d);
        cycle(1'b1, d, 1'b1, 1'b0);
        cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    endtask

    function automatic logic [33:0] model_vec();
        return {m_a, m_b, m_sel, m_sel, m_op, m_val, 2'(m_presses % 4), m_cnt};
    endfunction

    function automatic logic [33:0] dut_vec();
        return {bus.A, bus.B, bus.selector1, bus.selector2, bus.operacion, bus.valido,
                bus.etapa, bus.operaciones};
    endfunction

    task automatic test_reset();
        cycle(1'b0, 8'hFF, 1'b0, 1'b0);
        cycle(1'b0, 8'hFF, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== 34'd0) begin
            bad++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 34'd0);
        end
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_full_load();
        press(8'h3C);
        cycle(1'b1, 8'h05, 1'b1, 1'b0);
        total++;
        if (bus.etapa !== 2'b10 || bus.B !== 8'h05 || bus.valido !== 1'b0) begin
            bad++; $display("FAIL load_b etapa=%b B=%h valido=%b want 10/05/0", bus.etapa, bus.B, bus.valido);
        end
        cycle(1'b1, 8'h05, 1'b0, 1'b0);
        cycle(1'b1, 8'h0A, 1'b1, 1'b0);
        total++;
        if ({bus.A, bus.B, bus.operacion, bus.selector1, bus.selector2, bus.valido, bus.etapa, bus.operaciones}
            !== {8'h3C, 8'h05, 1'b1, 3'b010, 3'b010, 1'b1, 2'b11, 8'd1}) begin
            bad++; $display("FAIL full_load A=%h B=%h op=%b s1=%b s2=%b v=%b etapa=%b cnt=%0d want 3C 05 1 010 010 1 11 1",
                bus.A, bus.B, bus.operacion, bus.selector1, bus.selector2, bus.valido, bus.etapa, bus.operaciones);
        end
        // Switch changes while holding in LISTO must not disturb the presented set.
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        cycle(1'b1, 8'h81, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL listo_hold got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_leave_listo();
        press(8'h99);
        total++;
        if (bus.valido !== 1'b0 || bus.etapa !== 2'b00 || bus.A !== 8'h3C || bus.B !== 8'h05) begin
            bad++; $display("FAIL leave_listo v=%b etapa=%b A=%h B=%h want 0 00 3C 05", bus.valido, bus.etapa, bus.A, bus.B);
        end
        press(8'h77);
        total++;
        if (bus.A !== 8'h77 || bus.B !== 8'h05 || bus.etapa !== 2'b01) begin
            bad++; $display("FAIL reload_a A=%h B=%h etapa=%b want 77 05 01", bus.A, bus.B, bus.etapa);
        end
    endtask

    task automatic test_held_button();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        total++;
        if (bus.etapa !== 2'b10 || bus.B !== 8'h40) begin
            bad++; $display("FAIL held_button etapa=%b B=%h want 10 40", bus.etapa, bus.B);
        end
    endtask

    task automatic test_reset_held();
        cycle(1'b0, 8'h55, 1'b1, 1'b0);
        cycle(1'b0, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h55, 1'b1, 1'b0);
        total++;
        if (bus.etapa !== 2'b00 || bus.A !== 8'h00) begin
            bad++; $display("FAIL reset_held etapa=%b A=%h want 00 00", bus.etapa, bus.A);
        end
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b1, 1'b0);
        total++;
        if (bus.etapa !== 2'b01 || bus.A !== 8'h66) begin
            bad++; $display("FAIL reset_held_repress etapa=%b A=%h want 01 66", bus.etapa, bus.A);
        end
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_clear_priority();
        cycle(1'b1, 8'hAB, 1'b1, 1'b1);
        total++;
        if (bus.A !== 8'h00 || bus.B !== 8'h00 || bus.etapa !== 2'b00 || bus.valido !== 1'b0) begin
            bad++; $display("FAIL clear_vs_load A=%h B=%h etapa=%b v=%b want 00 00 00 0", bus.A, bus.B, bus.etapa, bus.valido);
        end
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic c, bo, r;
        for (int i = 0; i < 400; i++) begin
            c  = ($urandom_range(0, 1) == 1);
            bo = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 63) != 0);
            cycle(r, 8'($urandom), c, bo);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL random[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
        for (int s = 0; s < 256; s++) begin
            for (int k = 0; k < 4; k++) press(8'($urandom));
            if (s == 254) begin
                total++;
                if (bus.operaciones !== 8'd255) begin
                    bad++; $display("FAIL count_255 got=%0d want=255", bus.operaciones);
                end
            end
        end
        total++;
        if (bus.operaciones !== 8'd0) begin
            bad++; $display("FAIL count_wrap got=%0d want=0", bus.operaciones);
        end
        for (int k = 0; k < 3; k++) press(8'($urandom));
        cycle(1'b1, 8'h00, 1'b0, 1'b1);
        total++;
        if (bus.operaciones !== 8'd1 || bus.valido !== 1'b0 || bus.etapa !== 2'b00) begin
            bad++; $display("FAIL clear_keeps_count cnt=%0d v=%b etapa=%b want 1 0 00", bus.operaciones, bus.valido, bus.etapa);
        end
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL wrap_final got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; bus.din = '0; bus.cargar = 1'b0; bus.borrar = 1'b0;
        m_presses = 0; m_prev = 1'b1;
        @(negedge clk);
        test_reset();
        test_full_load();
        test_leave_listo();
        test_held_button();
        test_reset_held();
        press(8'h12);
        test_clear_priority();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
